// File: rtl/wb_reg_bank_pkg.sv
// Shared constants and helpers for the wb_reg_bank Wishbone register slave.
package wb_reg_bank_pkg;

    localparam int unsigned WB_DW = 32;
    localparam int unsigned WB_SW = 4;

    // Expand byte-lane selects into a per-bit write mask.
    function automatic logic [WB_DW-1:0] sel_to_mask(input logic [WB_SW-1:0] sel);
        logic [WB_DW-1:0] m;
        m = '0;
        for (int unsigned k = 0; k < WB_SW; k++) begin
            m[8*k +: 8] = {8{sel[k]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/wb_reg_bank_if.sv
// Wishbone classic-pipelined handshake for wb_reg_bank.
// Accepts each access once (rip/wip), produces one-cycle rd/wr requests with
// captured address/select/data, and registers ack/err from the decode result.
// Optional macro WB_REG_BANK_PIPE_EN adds one request stage (latency 2).
module wb_reg_bank_if
    import wb_reg_bank_pkg::*;
#(
    parameter int unsigned ADDR_W = 6
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              wb_cyc_i,
    input  logic              wb_stb_i,
    input  logic              wb_we_i,
    input  logic [ADDR_W-1:0] wb_adr_i,
    input  logic [WB_SW-1:0]  wb_sel_i,
    input  logic [WB_DW-1:0]  wb_dat_i,
    input  logic              hit_i,
    output logic              wb_stall_o,
    output logic              wb_ack_o,
    output logic              wb_err_o,
    output logic              rd_req_o,
    output logic              wr_req_o,
    output logic [ADDR_W-1:0] adr_o,
    output logic [WB_SW-1:0]  sel_o,
    output logic [WB_DW-1:0]  dat_o
);

    logic rip_q, rip_d;
    logic wip_q, wip_d;
    logic ack_q, ack_d;
    logic err_q, err_d;
    logic en, done, rd_acc, wr_acc;

    assign en     = wb_cyc_i & wb_stb_i;
    assign done   = ack_q | err_q;
    assign rd_acc = en & ~wb_we_i & ~rip_q;
    assign wr_acc = en &  wb_we_i & ~wip_q;

    assign wb_stall_o = ~done & en;
    assign wb_ack_o   = ack_q;
    assign wb_err_o   = err_q;

    // In-progress flags and response generation for the presented request.
    always_comb begin
        rip_d = rip_q;
        wip_d = wip_q;
        if (done) begin
            rip_d = 1'b0;
            wip_d = 1'b0;
        end
        if (rd_acc) rip_d = 1'b1;
        if (wr_acc) wip_d = 1'b1;
        ack_d = (rd_req_o | wr_req_o) &  hit_i;
        err_d = (rd_req_o | wr_req_o) & ~hit_i;
    end

    // Handshake state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rip_q <= 1'b0;
            wip_q <= 1'b0;
            ack_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            rip_q <= rip_d;
            wip_q <= wip_d;
            ack_q <= ack_d;
            err_q <= err_d;
        end
    end

`ifdef WB_REG_BANK_PIPE_EN
    logic              rd_q, wr_q;
    logic [ADDR_W-1:0] adr_q;
    logic [WB_SW-1:0]  sel_q;
    logic [WB_DW-1:0]  dat_q;

    // Request stage; reads pass through it too so decode and sts sampling
    // happen one cycle later and read data still lands with the ack.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_q  <= 1'b0;
            wr_q  <= 1'b0;
            adr_q <= '0;
            sel_q <= '0;
            dat_q <= '0;
        end else begin
            rd_q  <= rd_acc;
            wr_q  <= wr_acc;
            adr_q <= wb_adr_i;
            sel_q <= wb_sel_i;
            dat_q <= wb_dat_i;
        end
    end

    assign rd_req_o = rd_q;
    assign wr_req_o = wr_q;
    assign adr_o    = adr_q;
    assign sel_o    = sel_q;
    assign dat_o    = dat_q;
`else
    assign rd_req_o = rd_acc;
    assign wr_req_o = wr_acc;
    assign adr_o    = wb_adr_i;
    assign sel_o    = wb_sel_i;
    assign dat_o    = wb_dat_i;
`endif

endmodule

// File: rtl/wb_reg_bank.sv
// wb_reg_bank: Wishbone bank of N_REGS 32-bit control/status registers with
// byte-lane writes, read-only status slots, unmapped-address error and
// per-register write pulses. Define WB_REG_BANK_PIPE_EN for one extra stage.
module wb_reg_bank
    import wb_reg_bank_pkg::*;
#(
    parameter int unsigned              N_REGS  = 4,
    parameter int unsigned              ADDR_W  = 6,
    parameter logic [N_REGS-1:0]        RO_MASK = '0,
    parameter logic [N_REGS*WB_DW-1:0]  RST_VAL = '0
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      wb_cyc_i,
    input  logic                      wb_stb_i,
    input  logic                      wb_we_i,
    input  logic [ADDR_W-1:0]         wb_adr_i,
    input  logic [WB_SW-1:0]          wb_sel_i,
    input  logic [WB_DW-1:0]          wb_dat_i,
    output logic                      wb_ack_o,
    output logic                      wb_err_o,
    output logic                      wb_rty_o,
    output logic                      wb_stall_o,
    output logic [WB_DW-1:0]          wb_dat_o,
    output logic [N_REGS*WB_DW-1:0]   regs_o,
    input  logic [N_REGS*WB_DW-1:0]   sts_i,
    output logic [N_REGS-1:0]         wr_pulse_o
);

    logic                     rd_req, wr_req, hit;
    logic [ADDR_W-1:0]        adr_c;
    logic [WB_SW-1:0]         sel_c;
    logic [WB_DW-1:0]         wdat_c, wmask, rdata;
    logic [N_REGS-1:0]        wr_en;
    logic [N_REGS*WB_DW-1:0]  regs_w;
    logic [N_REGS-1:0]        wr_pulse_q;
    logic [WB_DW-1:0]         dat_q, dat_d;

    wb_reg_bank_if #(.ADDR_W(ADDR_W)) u_if (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .wb_cyc_i   (wb_cyc_i),
        .wb_stb_i   (wb_stb_i),
        .wb_we_i    (wb_we_i),
        .wb_adr_i   (wb_adr_i),
        .wb_sel_i   (wb_sel_i),
        .wb_dat_i   (wb_dat_i),
        .hit_i      (hit),
        .wb_stall_o (wb_stall_o),
        .wb_ack_o   (wb_ack_o),
        .wb_err_o   (wb_err_o),
        .rd_req_o   (rd_req),
        .wr_req_o   (wr_req),
        .adr_o      (adr_c),
        .sel_o      (sel_c),
        .dat_o      (wdat_c)
    );

    assign hit      = 32'(adr_c) < N_REGS;
    assign wmask    = sel_to_mask(sel_c);
    assign wb_rty_o = 1'b0;
    assign regs_o   = regs_w;

    // Per-register write enable; read-only slots never take writes.
    always_comb begin
        wr_en = '0;
        for (int unsigned i = 0; i < N_REGS; i++) begin
            wr_en[i] = wr_req & hit & (32'(adr_c) == i) & ~RO_MASK[i];
        end
    end

    for (genvar g = 0; g < N_REGS; g++) begin : g_reg
        logic [WB_DW-1:0] reg_q, reg_d;

        // Byte-lane merge of write data into the current contents.
        always_comb begin
            reg_d = reg_q;
            if (wr_en[g]) reg_d = (reg_q & ~wmask) | (wdat_c & wmask);
        end

        // Register storage with per-slot reset value.
        always_ff @(posedge clk_i) begin
            if (rst_i) reg_q <= RST_VAL[WB_DW*g +: WB_DW];
            else       reg_q <= reg_d;
        end

        assign regs_w[WB_DW*g +: WB_DW] = reg_q;
    end

    // Read mux: RO slots return live status, misses return zero.
    always_comb begin
        rdata = '0;
        for (int unsigned i = 0; i < N_REGS; i++) begin
            if (32'(adr_c) == i) begin
                rdata = RO_MASK[i] ? sts_i[WB_DW*i +: WB_DW] : regs_w[WB_DW*i +: WB_DW];
            end
        end
        dat_d = rd_req ? rdata : '0;
    end

    // Registered read data and write pulses, aligned with ack/err.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dat_q      <= '0;
            wr_pulse_q <= '0;
        end else begin
            dat_q      <= dat_d;
            wr_pulse_q <= wr_en;
        end
    end

    assign wb_dat_o   = dat_q;
    assign wr_pulse_o = wr_pulse_q;

endmodule

// File: tb/tb_wb_reg_bank.sv
// Scoreboard bench for wb_reg_bank: stimulus pushes expected responses,
// a negedge monitor pops and compares on every ack/err.
module tb_wb_reg_bank;

    localparam int unsigned NR = 4;
    localparam int unsigned AW = 6;
    localparam logic [NR-1:0]    ROM  = 4'b1000;
    localparam logic [NR*32-1:0] RSTV = {32'h0BAD_F00D, 32'h1234_5678,
                                         32'hC0DE_0001, 32'hA5A5_5A5A};
`ifdef WB_REG_BANK_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic              clk = 1'b0;
    logic              rst_i;
    logic              cyc, stb, we;
    logic [AW-1:0]     adr;
    logic [3:0]        sel;
    logic [31:0]       wdat;
    logic              ack, err, rty, stall;
    logic [31:0]       rdat;
    logic [NR*32-1:0]  regs, sts;
    logic [NR-1:0]     pulse;

    wb_reg_bank #(
        .N_REGS  (NR),
        .ADDR_W  (AW),
        .RO_MASK (ROM),
        .RST_VAL (RSTV)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .wb_cyc_i   (cyc),
        .wb_stb_i   (stb),
        .wb_we_i    (we),
        .wb_adr_i   (adr),
        .wb_sel_i   (sel),
        .wb_dat_i   (wdat),
        .wb_ack_o   (ack),
        .wb_err_o   (err),
        .wb_rty_o   (rty),
        .wb_stall_o (stall),
        .wb_dat_o   (rdat),
        .regs_o     (regs),
        .sts_i      (sts),
        .wr_pulse_o (pulse)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit               is_err;
        bit               is_rd;
        logic [31:0]      rdata;
        logic [NR-1:0]    pulse;
        logic [NR*32-1:0] regs;
        int               issue;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] model[NR];
    logic [NR*32-1:0] rwm;
    int total = 0, bad = 0, cyc_cnt = 0, ack_cnt = 0;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic chk(input string name, input logic [NR*32-1:0] act, input logic [NR*32-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [NR*32-1:0] model_flat();
        logic [NR*32-1:0] f;
        for (int i = 0; i < NR; i++) f[32*i +: 32] = model[i];
        return f;
    endfunction

    // Monitor: every response is matched against the oldest expectation.
    always @(negedge clk) begin
        if (!rst_i) begin
            if (ack || err) begin
                ack_cnt++;
                chk("ack_err_exclusive", {127'd0, ack & err}, '0);
                chk("rty", {127'd0, rty}, '0);
                if (sbq.size() == 0) begin
                    chk("unexpected_resp", {126'd0, ack, err}, '0);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("err", {127'd0, err}, {127'd0, e.is_err});
                    chk("ack", {127'd0, ack}, {127'd0, !e.is_err});
                    if (e.issue >= 0) chk("latency", 128'(cyc_cnt - e.issue), 128'(LAT));
                    chk("wr_pulse", {124'd0, pulse}, {124'd0, e.pulse});
                    chk("regs", regs & rwm, e.regs & rwm);
                    if (e.is_rd || e.is_err) chk("rdata", {96'd0, rdat}, {96'd0, e.rdata});
                end
            end else begin
                chk("idle_pulse", {124'd0, pulse}, '0);
            end
        end
    end

    task automatic wait_idle();
        for (int i = 0; i < 12; i++) begin
            if (sbq.size() == 0) break;
            @(posedge clk);
        end
        chk("resp_timeout", 128'(sbq.size()), '0);
        sbq.delete();
    endtask

    // Build the expectation from the register-map rules, then drive one request.
    task automatic issue(input bit w, input logic [AW-1:0] a, input logic [3:0] s, input logic [31:0] d);
        exp_t e;
        int   ai;
        ai       = int'(a);
        e.is_rd  = !w;
        e.is_err = (ai >= NR);
        e.pulse  = '0;
        e.rdata  = '0;
        if (!e.is_err) begin
            if (w) begin
                if (!ROM[ai]) begin
                    for (int k = 0; k < 4; k++)
                        if (s[k]) model[ai][8*k +: 8] = d[8*k +: 8];
                    e.pulse[ai] = 1'b1;
                end
            end else begin
                e.rdata = ROM[ai] ? sts[32*ai +: 32] : model[ai];
            end
        end
        e.regs = model_flat();
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; wdat = d;
        e.issue = cyc_cnt;
        sbq.push_back(e);
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        wait_idle();
    endtask

    initial begin
        logic [31:0] rst_chk;
        int          target;
        rst_i = 1'b1; cyc = 0; stb = 0; we = 0; adr = '0; sel = '0; wdat = '0;
        sts = '0;
        rwm = '0;
        for (int i = 0; i < NR; i++) begin
            model[i] = RSTV[32*i +: 32];
            if (!ROM[i]) rwm[32*i +: 32] = '1;
        end
        repeat (3) @(negedge clk);
        rst_i = 1'b0;
        @(negedge clk);
        chk("rst_ack", {127'd0, ack}, '0);
        chk("rst_err", {127'd0, err}, '0);
        chk("rst_dat", {96'd0, rdat}, '0);
        chk("rst_pulse", {124'd0, pulse}, '0);
        chk("rst_regs", regs & rwm, RSTV & rwm);

        // Reset values read back through the bus
        sts[32*3 +: 32] = 32'h5555_AAAA;
        for (int i = 0; i < NR; i++) issue(1'b0, AW'(i), 4'h0, '0);

        // Full-word write and readback
        issue(1'b1, AW'(1), 4'hF, 32'hDEAD_BEEF);
        issue(1'b0, AW'(1), 4'h0, '0);

        // Byte lanes
        issue(1'b1, AW'(2), 4'hF, 32'h1122_3344);
        issue(1'b1, AW'(2), 4'b0101, 32'hAABB_CCDD);
        issue(1'b0, AW'(2), 4'h0, '0);
        issue(1'b1, AW'(0), 4'b0000, 32'hFFFF_FFFF);
        issue(1'b0, AW'(0), 4'h0, '0);

        // Read-only status slot
        sts[32*3 +: 32] = 32'h0000_CAFE;
        issue(1'b1, AW'(3), 4'hF, 32'hFFFF_FFFF);
        issue(1'b0, AW'(3), 4'h0, '0);

        // Unmapped addresses
        issue(1'b0, AW'(NR), 4'h0, '0);
        issue(1'b1, AW'(NR), 4'hF, 32'h1234_0000);
        issue(1'b1, AW'(63), 4'hF, 32'h0F0F_0F0F);

        // Random traffic
        for (int n = 0; n < 60; n++) begin
            int unsigned r;
            logic [AW-1:0] ra;
            sts = {$urandom, $urandom, $urandom, $urandom};
            r   = $urandom_range(0, 9);
            ra  = (r <= NR) ? AW'(r) : AW'($urandom_range(0, 63));
            issue(1'($urandom_range(0, 1)), ra, 4'($urandom), $urandom);
        end

        // Reset coincident with a write request: dropped entirely
        @(negedge clk);
        rst_i = 1'b1; cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = AW'(1); sel = 4'hF; wdat = 32'h7777_7777;
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(negedge clk);
        rst_i = 1'b0;
        for (int i = 0; i < NR; i++) model[i] = RSTV[32*i +: 32];
        repeat (4) @(negedge clk);
        chk("post_rst_regs", regs & rwm, RSTV & rwm);
        rst_chk = RSTV[32 +: 32];
        issue(1'b0, AW'(1), 4'h0, '0);
        chk("post_rst_model", {96'd0, model[1]}, {96'd0, rst_chk});

        // Eight back-to-back reads with strobe held
        issue(1'b1, AW'(2), 4'hF, 32'h600D_CAFE);
        for (int i = 0; i < 8; i++) begin
            exp_t e;
            e.is_err = 0; e.is_rd = 1; e.rdata = model[2]; e.pulse = '0;
            e.regs = model_flat(); e.issue = -1;
            sbq.push_back(e);
        end
        target = ack_cnt + 8;
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = AW'(2);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            #1;
            if (ack_cnt >= target) break;
        end
        cyc = 1'b0; stb = 1'b0;
        chk("b2b_count", 128'(ack_cnt), 128'(target));
        wait_idle();
        repeat (4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
